// File: rtl/sdu_uart_tx.sv
// Byte-queued 8N1 UART transmitter (LSB first) with a power-of-two circular FIFO.
// Frames run back-to-back while data is queued; writes to a full FIFO are dropped and flagged in ovf.
module sdu_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             din,
  input  logic                   wr_en,
  output logic                   txd,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_txd;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_ovf;

  state_t          w_state_nxt;
  logic [BW-1:0]   w_baud_nxt;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      w_shift_nxt;
  logic            w_txd_nxt;
  logic            w_pop;
  logic            w_bit_end;
  logic            w_has_data;
  logic            w_full;
  logic            w_wr_ok;

  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_has_data = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  // Acceptance uses the pre-edge count, so a pop on the same edge never frees a slot for a write.
  assign w_wr_ok    = wr_en && !w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (w_has_data) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The line level is registered from the next state so txd is glitch-free and aligned to state entry.
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= din;
  end

  assign txd   = r_txd;
  assign full  = w_full;
  assign empty = !w_has_data;
  assign busy  = (r_state != S_IDLE);
  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_sdu_uart_tx.sv
// Randomized and directed bench for sdu_uart_tx at DIV=16, DEPTH=4, against a frame-timing queue model.
module tb_sdu_uart_tx;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       txd, full, empty, busy, ovf;
  logic [2:0] count;

  always #5 clk = ~clk;

  sdu_uart_tx #(.CLK_FREQ(16), .BAUD(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .txd(txd),
    .full(full), .empty(empty), .busy(busy), .count(count), .ovf(ovf)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: queued bytes, cycles left in the frame on the line, byte on the line.
  logic [7:0] m_q[$];
  int         m_left = 0;
  logic [7:0] m_cur  = 8'h00;
  logic       m_ovf  = 1'b0;
  logic [7:0] exp_tx[$];

  // Line decoder: watches txd like a host receiver sampling mid-bit.
  logic       rx_act = 1'b0;
  int         rx_t   = 0;
  logic [7:0] rx_sh  = 8'h00;
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d);
    int   pre;
    int   el;
    int   slot;
    logic exp_txd;
    rst = r; wr_en = w; din = d;
    @(posedge clk);
    cyc++;
    if (r) begin
      if (m_left > 0) void'(exp_tx.pop_back());
      m_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      pre = m_q.size();
      if (m_left > 0) m_left--;
      if (m_left == 0 && pre != 0) begin
        m_cur = m_q.pop_front();
        exp_tx.push_back(m_cur);
        m_left = FRAME;
      end
      if (w) begin
        if (pre < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    #1;
    if (m_left == 0) exp_txd = 1'b1;
    else begin
      el   = FRAME - m_left;
      slot = el / DIV;
      exp_txd = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : m_cur[slot-1];
    end
    check("txd",   32'(txd),   32'(exp_txd));
    check("busy",  32'(busy),  32'(m_left > 0));
    check("count", 32'(count), 32'(m_q.size()));
    check("full",  32'(full),  32'(m_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("ovf",   32'(ovf),   32'(m_ovf));
    if (r) rx_act = 1'b0;
    else if (!rx_act) begin
      if (txd == 1'b0) begin
        rx_act = 1'b1;
        rx_t   = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % DIV == DIV / 2) begin
        slot = rx_t / DIV;
        if (slot == 0) check("start_bit", 32'(txd), 32'd0);
        else if (slot <= 8) rx_sh[slot-1] = txd;
        else begin
          check("stop_bit", 32'(txd), 32'd1);
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_tx.size()));
    n = (rx_q.size() < exp_tx.size()) ? rx_q.size() : exp_tx.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_tx[i]));
    rx_q.delete();
    exp_tx.delete();
  endtask

  initial begin
    int guard;
    // Reset and quiet line
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    idle(100);

    // Single byte 0x55: busy high through stop, low one cycle later
    step(1'b0, 1'b1, 8'h55);
    check("t2_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    check("t2_start", 32'(txd), 32'd0);
    idle(159);
    check("t2_busy_hi", 32'(busy), 32'd1);
    idle(1);
    check("t2_busy_lo", 32'(busy), 32'd0);
    idle(20);
    check("t2_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) check("t2_byte", 32'(rx_q[0]), 32'h55);
    compare_rx("t2");

    // Three back-to-back frames, 480 cycles end to end
    step(1'b0, 1'b1, 8'hA3);
    step(1'b0, 1'b1, 8'h0F);
    step(1'b0, 1'b1, 8'hFF);
    idle(478);
    check("t3_busy_hi", 32'(busy), 32'd1);
    idle(1);
    check("t3_busy_lo", 32'(busy), 32'd0);
    idle(20);
    check("t3_n", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("t3_b0", 32'(rx_q[0]), 32'hA3);
      check("t3_b1", 32'(rx_q[1]), 32'h0F);
      check("t3_b2", 32'(rx_q[2]), 32'hFF);
    end
    compare_rx("t3");

    // Overflow: eight writes, five survive
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i));
    check("t4_count", 32'(count), 32'd4);
    check("t4_full", 32'(full), 32'd1);
    check("t4_ovf", 32'(ovf), 32'd1);
    idle(5 * FRAME + 20);
    check("t4_ovf_sticky", 32'(ovf), 32'd1);
    check("t4_n", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check("t4_byte", 32'(rx_q[i]), 32'(i));
    compare_rx("t4");

    // Write while full on the same edge as a STOP->START pop
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i));
    check("t5_full", 32'(full), 32'd1);
    guard = 0;
    while (m_left != 1 && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
    check("t5_reached_stop_end", 32'(m_left), 32'd1);
    step(1'b0, 1'b1, 8'h99);
    check("t5_count", 32'(count), 32'd3);
    check("t5_ovf", 32'(ovf), 32'd1);
    idle(4 * FRAME + 20);
    compare_rx("t5");

    // Reset during data bit 3 of 0xC6 with two bytes queued
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hC6);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    guard = 0;
    while ((FRAME - m_left) != 4 * DIV + 6 && guard < FRAME) begin
      idle(1);
      guard++;
    end
    check("t6_in_bit3", 32'(FRAME - m_left), 32'(4 * DIV + 6));
    step(1'b1, 1'b0, 8'h00);
    check("t6_txd", 32'(txd), 32'd1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    idle(2 * FRAME);
    check("t6_no_frames", 32'(rx_q.size()), 32'd0);
    compare_rx("t6");

    // Random write traffic with bursts
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 2) step(1'b0, 1'b1, 8'($urandom));
      else idle(1);
    end
    idle((DEPTH + 1) * FRAME + 20);
    compare_rx("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
